// File: rtl/edge_detect_multi.sv
// ---------------------------------------------------------------------------
// edge_detect_multi
//   Multi-channel dual-edge detector. Each channel has an optional
//   synchroniser feeding a 4-state Moore FSM (LOW/RISE/HIGH/FALL). The block
//   produces Moore and Mealy edge pulses gated by a per-channel edge mode,
//   plus a saturating per-channel event counter.
//
// Parameters
//   CH          number of independent channels (>=1)
//   SYNC_STAGES synchroniser flops per channel (0 = din used directly)
//   CNT_W       width of each per-channel event counter (>=1)
//
// Ports
//   clk          single clock for all logic
//   rst          asynchronous active-high reset
//   din          raw channel inputs
//   mode         per channel [2i+1:2i]: bit0 = rising enable, bit1 = falling enable
//   clr          synchronous per-channel counter clear
//   pulse_moore  edge pulse decoded from registered state
//   pulse_mealy  edge pulse from state and input, one cycle ahead of Moore
//   evt_any      OR of all pulse_moore bits
//   cnt          per-channel counters, channel i at [i*CNT_W +: CNT_W]
// ---------------------------------------------------------------------------
module edge_detect_multi #(
    parameter int unsigned CH          = 4,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned CNT_W       = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [CH-1:0]         din,
    input  logic [2*CH-1:0]       mode,
    input  logic [CH-1:0]         clr,
    output logic [CH-1:0]         pulse_moore,
    output logic [CH-1:0]         pulse_mealy,
    output logic                  evt_any,
    output logic [CH*CNT_W-1:0]   cnt
);

    localparam int unsigned MODE_W = 2 * CH;
    localparam int unsigned CNT_TOT_W = CH * CNT_W;

    typedef enum logic [1:0] {
        ST_LOW  = 2'd0,
        ST_RISE = 2'd1,
        ST_HIGH = 2'd2,
        ST_FALL = 2'd3
    } state_e;

    // Synchronised channel levels
    logic [CH-1:0] sync_s;

    generate
        if (SYNC_STAGES == 0) begin : g_bypass
            // No synchroniser: the FSM samples din directly
            assign sync_s = din;
        end else begin : g_sync
            logic [CH-1:0] sync_q [SYNC_STAGES];
            logic [CH-1:0] sync_d [SYNC_STAGES];

            // Shift chain: stage 0 takes din, each later stage takes its predecessor
            always_comb begin
                sync_d[0] = din;
                for (int unsigned k = 1; k < SYNC_STAGES; k++) begin
                    sync_d[k] = sync_q[k-1];
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int unsigned k = 0; k < SYNC_STAGES; k++) begin
                        sync_q[k] <= '0;
                    end
                end else begin
                    for (int unsigned k = 0; k < SYNC_STAGES; k++) begin
                        sync_q[k] <= sync_d[k];
                    end
                end
            end

            assign sync_s = sync_q[SYNC_STAGES-1];
        end
    endgenerate

    // Per-channel FSM, pulse decode and counter
    genvar gi;
    generate
        for (gi = 0; gi < CH; gi++) begin : g_ch
            localparam logic [CNT_W-1:0] CNT_MAX = '1;

            state_e           state_q;
            state_e           state_d;
            logic [CNT_W-1:0] cnt_q;
            logic [CNT_W-1:0] cnt_d;
            logic             moore_c;
            logic             mealy_c;
            logic             rise_en;
            logic             fall_en;
            logic             lvl;

            assign rise_en = mode[2*gi];
            assign fall_en = mode[2*gi+1];
            assign lvl     = sync_s[gi];

            // State register
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    state_q <= ST_LOW;
                end else begin
                    state_q <= state_d;
                end
            end

            // Next state and edge pulses; the FSM tracks the level regardless
            // of mode, mode only gates the pulses
            always_comb begin
                state_d = state_q;
                moore_c = 1'b0;
                mealy_c = 1'b0;
                case (state_q)
                    ST_LOW: begin
                        if (lvl) begin
                            state_d = ST_RISE;
                        end
                        mealy_c = lvl & rise_en;
                    end
                    ST_RISE: begin
                        state_d = lvl ? ST_HIGH : ST_FALL;
                        moore_c = rise_en;
                        mealy_c = ~lvl & fall_en;
                    end
                    ST_HIGH: begin
                        if (!lvl) begin
                            state_d = ST_FALL;
                        end
                        mealy_c = ~lvl & fall_en;
                    end
                    ST_FALL: begin
                        state_d = lvl ? ST_RISE : ST_LOW;
                        moore_c = fall_en;
                        mealy_c = lvl & rise_en;
                    end
                    default: begin
                        state_d = ST_LOW;
                    end
                endcase
                // In bypass mode din can be high during reset; keep Mealy quiet
                if (rst) begin
                    mealy_c = 1'b0;
                end
            end

            // Counter register
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end

            // Saturating count of Moore pulses; clear beats a coincident pulse
            always_comb begin
                cnt_d = cnt_q;
                if (clr[gi]) begin
                    cnt_d = '0;
                end else if (moore_c && (cnt_q != CNT_MAX)) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            assign pulse_moore[gi]              = moore_c;
            assign pulse_mealy[gi]              = mealy_c;
            assign cnt[gi*CNT_W +: CNT_W]       = cnt_q;
        end
    endgenerate

    assign evt_any = |pulse_moore;

    // Width sanity for the flattened buses
    if (MODE_W != $bits(mode) || CNT_TOT_W != $bits(cnt)) begin : g_width_err
        $error("edge_detect_multi: bus width mismatch");
    end

endmodule

// File: tb/tb_edge_detect_multi.sv
// Scoreboarded bench for edge_detect_multi: three instances (main CH=4 with
// a 2-stage synchroniser, a 3-bit saturating counter variant, and a bypass
// variant). Stimulus pushes cycle-stamped expected pulses and counter
// snapshots; a negedge monitor pops and compares.
module tb_edge_detect_multi;

    typedef struct {
        int         cyc;
        logic [3:0] mealy;
        logic [3:0] moore;
        logic       evt;
    } ev_t;

    typedef struct {
        int          cyc;
        logic [31:0] cnt;
    } snap_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;

    // main instance
    logic [3:0]  din_m = '0;
    logic [7:0]  mode_m = 8'hFF;
    logic [3:0]  clr_m = '0;
    logic [3:0]  mo_m, me_m;
    logic        ev_m;
    logic [31:0] cnt_m;
    // saturation instance
    logic        din_s = 1'b0;
    logic [1:0]  mode_s = 2'b01;
    logic        clr_s = 1'b0;
    logic        mo_s, me_s, ev_s;
    logic [2:0]  cnt_s;
    // bypass instance
    logic        din_b = 1'b0;
    logic [1:0]  mode_b = 2'b11;
    logic        clr_b = 1'b0;
    logic        mo_b, me_b, ev_b;
    logic [7:0]  cnt_b;

    ev_t   ev_q [3][$];
    snap_t sn_q [3][$];

    int n_chk = 0;
    int n_pass = 0;
    logic final_req = 1'b0;

    edge_detect_multi #(.CH(4), .SYNC_STAGES(2), .CNT_W(8)) u_main (
        .clk(clk), .rst(rst), .din(din_m), .mode(mode_m), .clr(clr_m),
        .pulse_moore(mo_m), .pulse_mealy(me_m), .evt_any(ev_m), .cnt(cnt_m)
    );

    edge_detect_multi #(.CH(1), .SYNC_STAGES(2), .CNT_W(3)) u_sat (
        .clk(clk), .rst(rst), .din(din_s), .mode(mode_s), .clr(clr_s),
        .pulse_moore(mo_s), .pulse_mealy(me_s), .evt_any(ev_s), .cnt(cnt_s)
    );

    edge_detect_multi #(.CH(1), .SYNC_STAGES(0), .CNT_W(8)) u_byp (
        .clk(clk), .rst(rst), .din(din_b), .mode(mode_b), .clr(clr_b),
        .pulse_moore(mo_b), .pulse_mealy(me_b), .evt_any(ev_b), .cnt(cnt_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- monitor ----------------
    logic [3:0]  om [3];
    logic [3:0]  oo [3];
    logic        oe [3];
    logic [31:0] oc [3];
    ev_t         e_pop;
    snap_t       s_pop;

    always @(negedge clk) begin
        om[0] = me_m;          oo[0] = mo_m;          oe[0] = ev_m; oc[0] = cnt_m;
        om[1] = {3'b0, me_s};  oo[1] = {3'b0, mo_s};  oe[1] = ev_s; oc[1] = {29'b0, cnt_s};
        om[2] = {3'b0, me_b};  oo[2] = {3'b0, mo_b};  oe[2] = ev_b; oc[2] = {24'b0, cnt_b};
        for (int i = 0; i < 3; i++) begin
            if (rst) begin
                n_chk++;
                if (om[i] == 4'b0 && oo[i] == 4'b0 && oe[i] == 1'b0 && oc[i] == 32'b0)
                    n_pass++;
                else
                    $display("FAIL reset[%0d] cyc=%0d: got mealy=%b moore=%b evt=%b cnt=%0d, want all zero",
                             i, cyc, om[i], oo[i], oe[i], oc[i]);
            end else begin
                if (om[i] != 4'b0 || oo[i] != 4'b0 || oe[i]) begin
                    n_chk++;
                    if (ev_q[i].size() == 0) begin
                        $display("FAIL spurious[%0d] cyc=%0d: got mealy=%b moore=%b evt=%b, want no pulse",
                                 i, cyc, om[i], oo[i], oe[i]);
                    end else begin
                        e_pop = ev_q[i].pop_front();
                        if (e_pop.cyc == cyc && e_pop.mealy == om[i] &&
                            e_pop.moore == oo[i] && e_pop.evt == oe[i])
                            n_pass++;
                        else
                            $display("FAIL pulse[%0d]: got cyc=%0d mealy=%b moore=%b evt=%b, want cyc=%0d mealy=%b moore=%b evt=%b",
                                     i, cyc, om[i], oo[i], oe[i], e_pop.cyc, e_pop.mealy, e_pop.moore, e_pop.evt);
                    end
                end
                while (ev_q[i].size() != 0 && ev_q[i][0].cyc <= cyc) begin
                    e_pop = ev_q[i].pop_front();
                    n_chk++;
                    $display("FAIL missing[%0d] cyc=%0d: got no pulse, want mealy=%b moore=%b evt=%b",
                             i, e_pop.cyc, e_pop.mealy, e_pop.moore, e_pop.evt);
                end
                while (sn_q[i].size() != 0 && sn_q[i][0].cyc <= cyc) begin
                    s_pop = sn_q[i].pop_front();
                    n_chk++;
                    if (s_pop.cyc == cyc && s_pop.cnt == oc[i])
                        n_pass++;
                    else
                        $display("FAIL cnt[%0d] cyc=%0d: got %h, want %h (due cyc %0d)",
                                 i, cyc, oc[i], s_pop.cnt, s_pop.cyc);
                end
            end
            if (final_req) begin
                n_chk++;
                if (ev_q[i].size() == 0 && sn_q[i].size() == 0)
                    n_pass++;
                else
                    $display("FAIL leftover[%0d]: got %0d events %0d snapshots pending, want 0 0",
                             i, ev_q[i].size(), sn_q[i].size());
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_ev(input int inst, input int c, input logic [3:0] me,
                           input logic [3:0] mo, input logic ev);
        ev_t e;
        e.cyc = c; e.mealy = me; e.moore = mo; e.evt = ev;
        ev_q[inst].push_back(e);
    endtask

    task automatic push_sn(input int inst, input int c, input logic [31:0] v);
        snap_t s;
        s.cyc = c; s.cnt = v;
        sn_q[inst].push_back(s);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int c;
        int c2;

        // Reset with inputs toggling: all outputs must stay zero
        rst = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick(1);
            din_m = 4'($urandom);
            din_s = 1'($urandom);
            din_b = 1'b1;
        end
        din_m = '0; din_s = 1'b0; din_b = 1'b0;
        tick(1);
        rst = 1'b0;
        tick(4);

        // Rise latency on main ch0
        c = cyc;
        din_m[0] = 1'b1;
        push_ev(0, c + 2, 4'b0001, 4'b0000, 1'b0);
        push_ev(0, c + 3, 4'b0000, 4'b0001, 1'b1);
        push_sn(0, c + 4, 32'h0000_0001);
        tick(8);

        // Rise-only mode: fall is silent but tracked
        c = cyc;
        mode_m = 8'hFD;
        din_m[0] = 1'b0;
        push_sn(0, c + 5, 32'h0000_0001);
        tick(6);
        // Fall-only mode: silent rise, one fall pulse
        mode_m = 8'hFE;
        din_m[0] = 1'b1;
        tick(4);
        c = cyc;
        din_m[0] = 1'b0;
        push_ev(0, c + 2, 4'b0001, 4'b0000, 1'b0);
        push_ev(0, c + 3, 4'b0000, 4'b0001, 1'b1);
        push_sn(0, c + 4, 32'h0000_0002);
        tick(8);
        mode_m = 8'hFF;

        // One-cycle glitch on ch2: rise then fall on consecutive cycles
        c = cyc;
        push_ev(0, c + 2, 4'b0100, 4'b0000, 1'b0);
        push_ev(0, c + 3, 4'b0100, 4'b0100, 1'b1);
        push_ev(0, c + 4, 4'b0000, 4'b0100, 1'b1);
        push_sn(0, c + 6, 32'h0002_0002);
        din_m[2] = 1'b1;
        tick(1);
        din_m[2] = 1'b0;
        tick(8);

        // ch1 both edges, ch3 fall-only, simultaneously
        mode_m = 8'hBF;
        c = cyc;
        din_m = 4'b1010;
        push_ev(0, c + 2, 4'b0010, 4'b0000, 1'b0);
        push_ev(0, c + 3, 4'b0000, 4'b0010, 1'b1);
        tick(4);
        c2 = cyc;
        din_m = 4'b0000;
        push_ev(0, c2 + 2, 4'b1010, 4'b0000, 1'b0);
        push_ev(0, c2 + 3, 4'b0000, 4'b1010, 1'b1);
        push_sn(0, c2 + 4, 32'h0102_0202);
        tick(8);
        mode_m = 8'hFF;

        // Saturation: nine rising edges into a 3-bit counter
        for (int k = 1; k <= 9; k++) begin
            c = cyc;
            din_s = 1'b1;
            push_ev(1, c + 2, 4'b0001, 4'b0000, 1'b0);
            push_ev(1, c + 3, 4'b0000, 4'b0001, 1'b1);
            push_sn(1, c + 4, (k < 7) ? 32'(k) : 32'd7);
            tick(3);
            din_s = 1'b0;
            tick(3);
        end

        // Clear coincident with a pulse: result 0, edge not counted
        c = cyc;
        din_s = 1'b1;
        push_ev(1, c + 2, 4'b0001, 4'b0000, 1'b0);
        push_ev(1, c + 3, 4'b0000, 4'b0001, 1'b1);
        push_sn(1, c + 4, 32'd0);
        tick(3);
        clr_s = 1'b1;
        din_s = 1'b0;
        tick(1);
        clr_s = 1'b0;
        tick(2);
        c = cyc;
        din_s = 1'b1;
        push_ev(1, c + 2, 4'b0001, 4'b0000, 1'b0);
        push_ev(1, c + 3, 4'b0000, 4'b0001, 1'b1);
        push_sn(1, c + 4, 32'd1);
        tick(3);
        din_s = 1'b0;
        tick(6);

        // Bypass: Mealy in the same cycle as din, Moore one cycle later
        c = cyc;
        din_b = 1'b1;
        push_ev(2, c, 4'b0001, 4'b0000, 1'b0);
        push_ev(2, c + 1, 4'b0000, 4'b0001, 1'b1);
        push_sn(2, c + 2, 32'd1);
        tick(3);
        c = cyc;
        din_b = 1'b0;
        push_ev(2, c, 4'b0001, 4'b0000, 1'b0);
        push_ev(2, c + 1, 4'b0000, 4'b0001, 1'b1);
        push_sn(2, c + 2, 32'd2);
        tick(4);

        // Reset between edges drops the in-flight Moore pulse and counters
        c = cyc;
        din_b = 1'b1;
        push_ev(2, c, 4'b0001, 4'b0000, 1'b0);
        tick(1);
        #1;
        rst = 1'b1;
        tick(2);
        // din still high at release: one rising edge reported
        rst = 1'b0;
        c = cyc;
        push_ev(2, c, 4'b0001, 4'b0000, 1'b0);
        push_ev(2, c + 1, 4'b0000, 4'b0001, 1'b1);
        push_sn(2, c + 2, 32'd1);
        tick(5);

        final_req = 1'b1;
        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
